// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-in-flight issue controller with RAW scoreboard, operand capture and ALU handshake.
// Optional ALU_CTRL_TRACE_EN adds TRACE_state/TRACE_pending/TRACE_stall_cnt observation ports.
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 12,
    parameter int STALL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DCR_valid,
    output logic              DCR_ready,
    input  logic              DCR_imm_sel,
    input  logic [IMM_W-1:0]  DCR_imm_val,
    input  logic [4:0]        DCR_rs1,
    input  logic [4:0]        DCR_rs2,
    input  logic [4:0]        DCR_rd,
    input  logic              DCR_rd_we,
    input  logic [3:0]        DCR_alu_op,
    output logic [4:0]        CTL_rs1_addr,
    output logic [4:0]        CTL_rs2_addr,
    input  logic [DATA_W-1:0] RAW_rs1_val,
    input  logic [DATA_W-1:0] RAW_rs2_val,
    output logic              CTL_imm_sel,
    output logic [IMM_W-1:0]  CTL_imm_val,
    output logic [DATA_W-1:0] CTL_rs1_val,
    output logic [DATA_W-1:0] CTL_rs2_val,
    output logic [3:0]        CTL_alu_op,
    output logic [4:0]        CTL_rd,
    output logic              CTL_alu_valid,
    input  logic              ALU_ready,
    input  logic              WB_valid,
    input  logic [4:0]        WB_rd,
    output logic              CTL_busy,
    output logic              CTL_stall_err
`ifdef ALU_CTRL_TRACE_EN
    ,
    output logic [1:0]        TRACE_state,
    output logic [31:0]       TRACE_pending,
    output logic [STALL_W-1:0] TRACE_stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, HAZ = 2'd1, ISSUE = 2'd2} state_t;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    state_t              r_state, w_state_nx;
    logic [31:0]         r_pending;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_stall_err;
    logic                r_imm_sel;
    logic [IMM_W-1:0]    r_imm_val;
    logic [4:0]          r_rs1, r_rs2, r_rd;
    logic                r_rd_we;
    logic [3:0]          r_alu_op;
    logic [DATA_W-1:0]   r_rs1_val, r_rs2_val;

    logic [31:0]         w_clr, w_set, w_pend_eff;
    logic                w_hazard, w_accept, w_issue_done;
    logic [STALL_W-1:0]  w_cnt_inc;

    assign w_accept     = (r_state == IDLE) && DCR_valid;
    assign w_issue_done = (r_state == ISSUE) && ALU_ready;
    assign w_clr        = (WB_valid && WB_rd != 5'd0) ? (32'd1 << WB_rd) : 32'd0;
    assign w_set        = (w_issue_done && r_rd_we && r_rd != 5'd0) ? (32'd1 << r_rd) : 32'd0;
    // Writeback in the same cycle releases the stall immediately.
    assign w_pend_eff   = r_pending & ~w_clr;
    assign w_hazard     = (r_rs1 != 5'd0 && w_pend_eff[r_rs1]) ||
                          (!r_imm_sel && r_rs2 != 5'd0 && w_pend_eff[r_rs2]);
    assign w_cnt_inc    = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = DCR_valid ? HAZ : IDLE;
            HAZ:     w_state_nx = w_hazard ? HAZ : ISSUE;
            ISSUE:   w_state_nx = ALU_ready ? IDLE : ISSUE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
            r_imm_sel   <= 1'b0;
            r_imm_val   <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_alu_op    <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
        end else begin
            // Set is applied after clear so a same-index collision leaves the entry pending.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_accept) begin
                r_imm_sel <= DCR_imm_sel;
                r_imm_val <= DCR_imm_val;
                r_rs1     <= DCR_rs1;
                r_rs2     <= DCR_rs2;
                r_rd      <= DCR_rd;
                r_rd_we   <= DCR_rd_we;
                r_alu_op  <= DCR_alu_op;
            end
            if (r_state == HAZ) begin
                if (w_hazard) begin
                    r_stall_cnt <= w_cnt_inc;
                    if (w_cnt_inc == STALL_MAX) r_stall_err <= 1'b1;
                end else begin
                    r_stall_cnt <= '0;
                    r_rs1_val   <= RAW_rs1_val;
                    r_rs2_val   <= RAW_rs2_val;
                end
            end
        end
    end

    assign DCR_ready     = (r_state == IDLE);
    assign CTL_busy      = (r_state != IDLE);
    assign CTL_alu_valid = (r_state == ISSUE);
    assign CTL_rs1_addr  = r_rs1;
    assign CTL_rs2_addr  = r_rs2;
    assign CTL_imm_sel   = r_imm_sel;
    assign CTL_imm_val   = r_imm_val;
    assign CTL_rs1_val   = r_rs1_val;
    assign CTL_rs2_val   = r_rs2_val;
    assign CTL_alu_op    = r_alu_op;
    assign CTL_rd        = r_rd;
    assign CTL_stall_err = r_stall_err;

`ifdef ALU_CTRL_TRACE_EN
    assign TRACE_state     = r_state;
    assign TRACE_pending   = r_pending;
    assign TRACE_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl built with STALL_W=3.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DCR_valid = 1'b0, DCR_ready, DCR_imm_sel = 1'b0, DCR_rd_we = 1'b0;
    logic [11:0] DCR_imm_val = '0;
    logic [4:0]  DCR_rs1 = '0, DCR_rs2 = '0, DCR_rd = '0;
    logic [3:0]  DCR_alu_op = '0;
    logic [4:0]  CTL_rs1_addr, CTL_rs2_addr, CTL_rd;
    logic [31:0] RAW_rs1_val, RAW_rs2_val, CTL_rs1_val, CTL_rs2_val;
    logic        CTL_imm_sel, CTL_alu_valid, CTL_busy, CTL_stall_err;
    logic [11:0] CTL_imm_val;
    logic [3:0]  CTL_alu_op;
    logic        ALU_ready = 1'b1, WB_valid = 1'b0;
    logic [4:0]  WB_rd = '0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign RAW_rs1_val = 32'hA000_0000 | {27'd0, CTL_rs1_addr};
    assign RAW_rs2_val = 32'hB000_0000 | {27'd0, CTL_rs2_addr};

    alu_issue_ctrl #(.DATA_W(32), .IMM_W(12), .STALL_W(3)) dut (
        .clk(clk), .rst(rst),
        .DCR_valid(DCR_valid), .DCR_ready(DCR_ready), .DCR_imm_sel(DCR_imm_sel),
        .DCR_imm_val(DCR_imm_val), .DCR_rs1(DCR_rs1), .DCR_rs2(DCR_rs2), .DCR_rd(DCR_rd),
        .DCR_rd_we(DCR_rd_we), .DCR_alu_op(DCR_alu_op),
        .CTL_rs1_addr(CTL_rs1_addr), .CTL_rs2_addr(CTL_rs2_addr),
        .RAW_rs1_val(RAW_rs1_val), .RAW_rs2_val(RAW_rs2_val),
        .CTL_imm_sel(CTL_imm_sel), .CTL_imm_val(CTL_imm_val),
        .CTL_rs1_val(CTL_rs1_val), .CTL_rs2_val(CTL_rs2_val),
        .CTL_alu_op(CTL_alu_op), .CTL_rd(CTL_rd), .CTL_alu_valid(CTL_alu_valid),
        .ALU_ready(ALU_ready), .WB_valid(WB_valid), .WB_rd(WB_rd),
        .CTL_busy(CTL_busy), .CTL_stall_err(CTL_stall_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic imm_sel, input logic [11:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                          input logic [3:0] op);
        DCR_valid = 1'b1; DCR_imm_sel = imm_sel; DCR_imm_val = imm; DCR_rs1 = rs1;
        DCR_rs2 = rs2; DCR_rd = rd; DCR_rd_we = we; DCR_alu_op = op;
    endtask

    // Full uncontended pass through IDLE->HAZ->ISSUE->IDLE with ALU_ready high.
    task automatic run_simple(input logic [4:0] rd, input logic we);
        accept(1'b1, 12'h0, 5'd0, 5'd0, rd, we, 4'h0);
        tick; DCR_valid = 1'b0;
        tick; tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick;
        n_tests++; if (CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_alu_valid got %b exp 0", CTL_alu_valid); end
        n_tests++; if (CTL_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", CTL_busy); end
        n_tests++; if (CTL_stall_err !== 1'b0) begin n_fail++; $display("FAIL rst_stall_err got %b exp 0", CTL_stall_err); end
        n_tests++; if (CTL_rs1_val !== 32'd0 || CTL_imm_val !== 12'd0) begin n_fail++; $display("FAIL rst_regs got %h/%h exp 0/0", CTL_rs1_val, CTL_imm_val); end
        rst = 1'b0; tick;
        n_tests++; if (DCR_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", DCR_ready); end
    endtask

    task automatic test_imm_issue;
        ALU_ready = 1'b1;
        accept(1'b1, 12'hFFF, 5'd1, 5'd0, 5'd0, 1'b0, 4'h3);
        tick; DCR_valid = 1'b0;
        n_tests++; if (DCR_ready !== 1'b0 || CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL imm_c1 got ready=%b valid=%b exp 0 0", DCR_ready, CTL_alu_valid); end
        tick;
        n_tests++; if (CTL_alu_valid !== 1'b1 || DCR_ready !== 1'b0) begin n_fail++; $display("FAIL imm_c2 got valid=%b ready=%b exp 1 0", CTL_alu_valid, DCR_ready); end
        n_tests++; if (CTL_imm_sel !== 1'b1 || CTL_imm_val !== 12'hFFF || CTL_alu_op !== 4'h3) begin n_fail++; $display("FAIL imm_fields got %b %h %h exp 1 fff 3", CTL_imm_sel, CTL_imm_val, CTL_alu_op); end
        n_tests++; if (CTL_rs1_val !== 32'hA000_0001) begin n_fail++; $display("FAIL imm_rs1_val got %h exp a0000001", CTL_rs1_val); end
        tick;
        n_tests++; if (CTL_alu_valid !== 1'b0 || DCR_ready !== 1'b1) begin n_fail++; $display("FAIL imm_c3 got valid=%b ready=%b exp 0 1", CTL_alu_valid, DCR_ready); end
    endtask

    task automatic test_raw_stall;
        run_simple(5'd5, 1'b1);
        accept(1'b1, 12'h0, 5'd5, 5'd0, 5'd0, 1'b0, 4'h1);
        tick; DCR_valid = 1'b0;
        tick;
        n_tests++; if (CTL_alu_valid !== 1'b0 || CTL_busy !== 1'b1) begin n_fail++; $display("FAIL raw_hold got valid=%b busy=%b exp 0 1", CTL_alu_valid, CTL_busy); end
        tick;
        WB_valid = 1'b1; WB_rd = 5'd5;
        n_tests++; if (CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL raw_hold2 got %b exp 0", CTL_alu_valid); end
        tick; WB_valid = 1'b0;
        n_tests++; if (CTL_alu_valid !== 1'b1 || CTL_rs1_val !== 32'hA000_0005) begin n_fail++; $display("FAIL raw_release got %b %h exp 1 a0000005", CTL_alu_valid, CTL_rs1_val); end
        tick;
        accept(1'b1, 12'h0, 5'd5, 5'd0, 5'd0, 1'b0, 4'h1);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL raw_cleared got %b exp 1", CTL_alu_valid); end
        tick;
    endtask

    task automatic test_rs2_imm;
        run_simple(5'd5, 1'b1);
        accept(1'b1, 12'h0, 5'd0, 5'd5, 5'd0, 1'b0, 4'h2);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b1 || CTL_rs2_val !== 32'hB000_0005) begin n_fail++; $display("FAIL imm_skips_rs2 got %b %h exp 1 b0000005", CTL_alu_valid, CTL_rs2_val); end
        tick;
        accept(1'b0, 12'h0, 5'd0, 5'd5, 5'd0, 1'b0, 4'h2);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL rs2_hazard got %b exp 0", CTL_alu_valid); end
        WB_valid = 1'b1; WB_rd = 5'd5;
        tick; WB_valid = 1'b0;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL rs2_release got %b exp 1", CTL_alu_valid); end
        tick;
    endtask

    task automatic test_x0_and_set_wins;
        run_simple(5'd0, 1'b1);
        accept(1'b0, 12'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'h4);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall got %b exp 1", CTL_alu_valid); end
        tick;
        accept(1'b1, 12'h0, 5'd0, 5'd0, 5'd8, 1'b1, 4'h4);
        tick; DCR_valid = 1'b0; tick;
        WB_valid = 1'b1; WB_rd = 5'd8;
        tick; WB_valid = 1'b0;
        accept(1'b1, 12'h0, 5'd8, 5'd0, 5'd0, 1'b0, 4'h4);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL set_wins got %b exp 0", CTL_alu_valid); end
        WB_valid = 1'b1; WB_rd = 5'd8;
        tick; WB_valid = 1'b0;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL set_wins_release got %b exp 1", CTL_alu_valid); end
        tick;
    endtask

    task automatic test_back_pressure;
        ALU_ready = 1'b0;
        accept(1'b0, 12'h123, 5'd3, 5'd4, 5'd6, 1'b0, 4'hA);
        tick; DCR_valid = 1'b0; tick;
        for (int i = 0; i < 3; i++) begin
            accept(1'b1, 12'h3C5 + 12'(i), 5'd9, 5'd10, 5'd11, 1'b1, 4'h7);
            n_tests++;
            if (CTL_alu_valid !== 1'b1 || CTL_alu_op !== 4'hA || CTL_rd !== 5'd6 || CTL_imm_sel !== 1'b0 ||
                CTL_imm_val !== 12'h123 || CTL_rs1_val !== 32'hA000_0003 || CTL_rs2_val !== 32'hB000_0004 ||
                CTL_rs1_addr !== 5'd3 || DCR_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got v=%b op=%h rd=%0d imm=%h a=%h b=%h exp 1 a 6 123 a0000003 b0000004",
                         i, CTL_alu_valid, CTL_alu_op, CTL_rd, CTL_imm_val, CTL_rs1_val, CTL_rs2_val);
            end
            tick;
        end
        DCR_valid = 1'b0; ALU_ready = 1'b1;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL hold_last got %b exp 1", CTL_alu_valid); end
        tick;
        n_tests++; if (CTL_alu_valid !== 1'b0 || DCR_ready !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b %b exp 0 1", CTL_alu_valid, DCR_ready); end
    endtask

    task automatic test_stall_timeout;
        ALU_ready = 1'b1;
        run_simple(5'd9, 1'b1);
        run_simple(5'd11, 1'b1);
        n_tests++; if (CTL_stall_err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b exp 0", CTL_stall_err); end
        accept(1'b1, 12'h0, 5'd9, 5'd0, 5'd0, 1'b0, 4'h5);
        tick; DCR_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        n_tests++; if (CTL_stall_err !== 1'b0) begin n_fail++; $display("FAIL err_6cyc got %b exp 0", CTL_stall_err); end
        tick;
        n_tests++; if (CTL_stall_err !== 1'b1 || CTL_alu_valid !== 1'b0) begin n_fail++; $display("FAIL err_7cyc got err=%b valid=%b exp 1 0", CTL_stall_err, CTL_alu_valid); end
        ALU_ready = 1'b0; WB_valid = 1'b1; WB_rd = 5'd9;
        tick; WB_valid = 1'b0;
        n_tests++; if (CTL_stall_err !== 1'b1 || CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL err_sticky got err=%b valid=%b exp 1 1", CTL_stall_err, CTL_alu_valid); end
        tick;
        rst = 1'b1; tick; rst = 1'b0;
        n_tests++; if (CTL_alu_valid !== 1'b0 || CTL_stall_err !== 1'b0 || CTL_busy !== 1'b0) begin n_fail++; $display("FAIL rst_issue got v=%b err=%b busy=%b exp 0 0 0", CTL_alu_valid, CTL_stall_err, CTL_busy); end
        tick; ALU_ready = 1'b1;
        accept(1'b1, 12'h0, 5'd11, 5'd0, 5'd0, 1'b0, 4'h5);
        tick; DCR_valid = 1'b0; tick;
        n_tests++; if (CTL_alu_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pending got %b exp 1", CTL_alu_valid); end
        tick;
    endtask

    initial begin
        test_reset;
        test_imm_issue;
        test_raw_stall;
        test_rs2_imm;
        test_x0_and_set_wins;
        test_back_pressure;
        test_stall_timeout;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
